instruction_aligner: RTL and testbench

INSTRUCTION_ALIGNER -- requirements
Module: instruction_aligner

---
 rtl/instruction_aligner.sv | 225 ++++++++++++++++++++++
 tb/tb_instruction_aligner.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_aligner.sv
// Halfword-granular fetch aligner: buffers fetch words as 16-bit parcels and
// presents one whole instruction per handshake, expanding RV32C when enabled.
module instruction_aligner #(
   parameter int BUF_HW = 4,
   parameter int C_EN   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [31:0] fetch_data,
   input  logic [31:0] fetch_pc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        inst_is_compressed,
   output logic        inst_illegal
);
   localparam int PW = $clog2(BUF_HW);
   localparam int CW = $clog2(BUF_HW + 1);

   logic [15:0]   buf_mem [BUF_HW];
   logic [PW-1:0] head_reg, head_next;
   logic [PW-1:0] tail_reg, tail_next;
   logic [CW-1:0] count_reg, count_next;
   logic [31:0]   head_pc_reg, head_pc_next;

   logic [PW-1:0] tail_plus1, head_plus1;
   logic [CW-1:0] free_cnt, push_n, pop_n, need_n;
   logic          push, push_two, pop;
   logic [15:0]   hw0, hw1;
   logic          is_32;
   logic [32:0]   exp_res;
   logic          unused_pc_bits;

   // Pointer advance modulo BUF_HW (depth need not be a power of two).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr, input logic [1:0] n);
      logic [PW:0] sum;
      sum = {1'b0, ptr} + {{(PW-1){1'b0}}, n};
      if (sum >= (PW+1)'(BUF_HW)) begin
         sum = sum - (PW+1)'(BUF_HW);
      end
      return sum[PW-1:0];
   endfunction

   // Returns {illegal, expanded instruction} for one compressed parcel.
   function automatic logic [32:0] expand(input logic [15:0] hw);
      logic [31:0] d;
      logic        ill;
      logic [4:0]  rd, rs2, rdp, rs1p;
      logic [11:0] imm6s;
      logic [20:0] jimm;
      logic [12:0] bimm;
      logic [9:0]  uimm4spn, imm16sp;
      logic [6:0]  lwoff;
      logic [7:0]  lwspoff, swspoff;
      logic [19:0] luiimm;
      d        = '0;
      ill      = 1'b0;
      rd       = hw[11:7];
      rs2      = hw[6:2];
      rdp      = {2'b01, hw[4:2]};
      rs1p     = {2'b01, hw[9:7]};
      imm6s    = {{6{hw[12]}}, hw[12], hw[6:2]};
      uimm4spn = {hw[10:7], hw[12:11], hw[5], hw[6], 2'b00};
      lwoff    = {hw[5], hw[12:10], hw[6], 2'b00};
      lwspoff  = {hw[3:2], hw[12], hw[6:4], 2'b00};
      swspoff  = {hw[8:7], hw[12:9], 2'b00};
      imm16sp  = {hw[12], hw[4:3], hw[5], hw[2], hw[6], 4'b0000};
      luiimm   = {{14{hw[12]}}, hw[12], hw[6:2]};
      jimm     = {{9{hw[12]}}, hw[12], hw[8], hw[10:9], hw[6], hw[7], hw[2], hw[11], hw[5:3], 1'b0};
      bimm     = {{4{hw[12]}}, hw[12], hw[6:5], hw[2], hw[11:10], hw[4:3], 1'b0};
      case ({hw[1:0], hw[15:13]})
         5'b00_000: begin
            if (uimm4spn == '0) ill = 1'b1;
            else d = {2'b00, uimm4spn, 5'd2, 3'b000, rdp, 7'h13};
         end
         5'b00_010: d = {5'b0, lwoff, rs1p, 3'b010, rdp, 7'h03};
         5'b00_110: d = {5'b0, lwoff[6:5], rdp, rs1p, 3'b010, lwoff[4:0], 7'h23};
         5'b01_000: d = {imm6s, rd, 3'b000, rd, 7'h13};
         5'b01_001: d = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'h6f};
         5'b01_010: d = {imm6s, 5'd0, 3'b000, rd, 7'h13};
         5'b01_011: begin
            if (rd == 5'd2) begin
               if (imm16sp == '0) ill = 1'b1;
               else d = {{2{imm16sp[9]}}, imm16sp, 5'd2, 3'b000, 5'd2, 7'h13};
            end else begin
               if ({hw[12], hw[6:2]} == 6'd0) ill = 1'b1;
               else d = {luiimm, rd, 7'h37};
            end
         end
         5'b01_100: begin
            case (hw[11:10])
               2'b00: begin
                  if (hw[12]) ill = 1'b1;
                  else d = {7'b0000000, hw[6:2], rs1p, 3'b101, rs1p, 7'h13};
               end
               2'b01: begin
                  if (hw[12]) ill = 1'b1;
                  else d = {7'b0100000, hw[6:2], rs1p, 3'b101, rs1p, 7'h13};
               end
               2'b10: d = {imm6s, rs1p, 3'b111, rs1p, 7'h13};
               default: begin
                  // hw[12]=1 here selects the RV64 word ops, not part of RV32C.
                  if (hw[12]) ill = 1'b1;
                  else begin
                     case (hw[6:5])
                        2'b00:   d = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                        2'b01:   d = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                        2'b10:   d = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                        default: d = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                     endcase
                  end
               end
            endcase
         end
         5'b01_101: d = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, 7'h6f};
         5'b01_110: d = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b000, bimm[4:1], bimm[11], 7'h63};
         5'b01_111: d = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b001, bimm[4:1], bimm[11], 7'h63};
         5'b10_000: begin
            if (hw[12]) ill = 1'b1;
            else d = {7'b0000000, hw[6:2], rd, 3'b001, rd, 7'h13};
         end
         5'b10_010: begin
            if (rd == 5'd0) ill = 1'b1;
            else d = {4'b0000, lwspoff, 5'd2, 3'b010, rd, 7'h03};
         end
         5'b10_100: begin
            if (!hw[12]) begin
               if (rs2 != 5'd0) d = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'h33};
               else if (rd == 5'd0) ill = 1'b1;
               else d = {12'h000, rd, 3'b000, 5'd0, 7'h67};
            end else begin
               if (rs2 != 5'd0) d = {7'b0000000, rs2, rd, 3'b000, rd, 7'h33};
               else if (rd == 5'd0) d = 32'h0010_0073;
               else d = {12'h000, rd, 3'b000, 5'd1, 7'h67};
            end
         end
         5'b10_110: d = {4'b0000, swspoff[7:5], rs2, 5'd2, 3'b010, swspoff[4:0], 7'h23};
         default:   ill = 1'b1;
      endcase
      if (ill) d = {16'h0000, hw};
      return {ill, d};
   endfunction

   // Only bit 1 of the fetch address matters: it marks an upper-half-only word.
   assign unused_pc_bits = ^{fetch_pc[31:2], fetch_pc[0]};

   assign tail_plus1  = ptr_inc(tail_reg, 2'd1);
   assign head_plus1  = ptr_inc(head_reg, 2'd1);
   assign free_cnt    = CW'(BUF_HW) - count_reg;
   assign fetch_ready = !reset && !flush && (free_cnt >= CW'(2));
   assign push        = fetch_valid && fetch_ready;
   assign push_two    = !fetch_pc[1];
   assign push_n      = push ? (push_two ? CW'(2) : CW'(1)) : '0;

   for (genvar gi = 0; gi < BUF_HW; gi++) begin : g_buf
      always_ff @(posedge clk) begin
         if (push && (tail_reg == PW'(gi))) begin
            buf_mem[gi] <= push_two ? fetch_data[15:0] : fetch_data[31:16];
         end else if (push && push_two && (tail_plus1 == PW'(gi))) begin
            buf_mem[gi] <= fetch_data[31:16];
         end
      end
   end

   assign hw0     = buf_mem[head_reg];
   assign hw1     = buf_mem[head_plus1];
   assign is_32   = (hw0[1:0] == 2'b11);
   assign need_n  = is_32 ? CW'(2) : CW'(1);
   assign exp_res = (C_EN != 0) ? expand(hw0) : {1'b1, 16'h0000, hw0};
   assign pop     = inst_valid && inst_ready;
   assign pop_n   = pop ? need_n : '0;

   always_comb begin
      inst_valid         = !reset && !flush && (count_reg >= need_n);
      inst_data          = '0;
      inst_pc            = '0;
      inst_is_compressed = 1'b0;
      inst_illegal       = 1'b0;
      if (inst_valid) begin
         inst_data          = is_32 ? {hw1, hw0} : exp_res[31:0];
         inst_pc            = head_pc_reg;
         inst_is_compressed = !is_32;
         inst_illegal       = !is_32 && exp_res[32];
      end
   end

   always_comb begin
      head_next    = head_reg;
      tail_next    = tail_reg;
      count_next   = count_reg;
      head_pc_next = head_pc_reg;
      if (flush) begin
         head_next    = '0;
         tail_next    = '0;
         count_next   = '0;
         head_pc_next = flush_pc;
      end else begin
         if (push) tail_next = ptr_inc(tail_reg, push_two ? 2'd2 : 2'd1);
         if (pop) begin
            head_next    = ptr_inc(head_reg, is_32 ? 2'd2 : 2'd1);
            head_pc_next = head_pc_reg + (is_32 ? 32'd4 : 32'd2);
         end
         count_next = count_reg + push_n - pop_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_reg    <= '0;
         tail_reg    <= '0;
         count_reg   <= '0;
         head_pc_reg <= '0;
      end else begin
         head_reg    <= head_next;
         tail_reg    <= tail_next;
         count_reg   <= count_next;
         head_pc_reg <= head_pc_next;
      end
   end
endmodule

// File: tb/tb_instruction_aligner.sv
// Bench for instruction_aligner: directed sequences, a table of compressed
// encodings, and randomized instruction streams checked against a queue model.
module tb_instruction_aligner;
   localparam int BUF_HW = 4;

   logic        clk = 1'b0;
   logic        reset, fetch_valid, flush, inst_ready;
   logic [31:0] fetch_data, fetch_pc, flush_pc;
   logic        fetch_ready, inst_valid, inst_is_compressed, inst_illegal;
   logic [31:0] inst_data, inst_pc;
   logic        fetch_ready0, inst_valid0, inst_c0, inst_ill0;
   logic [31:0] inst_data0, inst_pc0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   instruction_aligner #(.BUF_HW(BUF_HW), .C_EN(1)) dut (
      .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .fetch_data(fetch_data), .fetch_pc(fetch_pc), .flush(flush), .flush_pc(flush_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .inst_pc(inst_pc), .inst_is_compressed(inst_is_compressed), .inst_illegal(inst_illegal)
   );

   instruction_aligner #(.BUF_HW(BUF_HW), .C_EN(0)) dut_nc (
      .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready0),
      .fetch_data(fetch_data), .fetch_pc(fetch_pc), .flush(flush), .flush_pc(flush_pc),
      .inst_valid(inst_valid0), .inst_ready(inst_ready), .inst_data(inst_data0),
      .inst_pc(inst_pc0), .inst_is_compressed(inst_c0), .inst_illegal(inst_ill0)
   );

   typedef struct { logic [15:0] hw; logic [31:0] data; logic ill; } cvec_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; logic c; logic ill; int size; } inst_t;
   cvec_t cvec [20];
   inst_t exp_q [$];

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush(input logic [31:0] pc);
      flush    = 1'b1;
      flush_pc = pc;
      #1;
      chk("flush_cycle", {inst_valid, fetch_ready}, 2'b00);
      step();
      flush = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] d, input logic [31:0] pc);
      int n;
      n           = 0;
      fetch_valid = 1'b1;
      fetch_data  = d;
      fetch_pc    = pc;
      #1;
      while (!fetch_ready && n < 50) begin
         step();
         #1;
         n++;
      end
      chk("fetch_accept", fetch_ready, 1'b1);
      step();
      fetch_valid = 1'b0;
   endtask

   task automatic expect_inst(input string name, input logic [31:0] d, input logic [31:0] pc,
                              input logic c, input logic ill);
      int n;
      n          = 0;
      inst_ready = 1'b1;
      #1;
      while (!inst_valid && n < 50) begin
         step();
         #1;
         n++;
      end
      chk({name, "_valid"}, inst_valid, 1'b1);
      chk(name, {inst_pc, inst_data, inst_is_compressed, inst_illegal}, {pc, d, c, ill});
      $display("inst %s pc=%h data=%h c=%0d ill=%0d", name, inst_pc, inst_data,
               inst_is_compressed, inst_illegal);
      step();
      inst_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] fpc;
      int          accepted;

      cvec[0]  = '{16'h0001, 32'h0000_0013, 1'b0};
      cvec[1]  = '{16'h4501, 32'h0000_0513, 1'b0};
      cvec[2]  = '{16'h0000, 32'h0000_0000, 1'b1};
      cvec[3]  = '{16'h1141, 32'hff01_0113, 1'b0};
      cvec[4]  = '{16'h8082, 32'h0000_8067, 1'b0};
      cvec[5]  = '{16'h4088, 32'h0004_a503, 1'b0};
      cvec[6]  = '{16'hc088, 32'h00a4_a023, 1'b0};
      cvec[7]  = '{16'h9002, 32'h0010_0073, 1'b0};
      cvec[8]  = '{16'h2000, 32'h0000_2000, 1'b1};
      cvec[9]  = '{16'h6081, 32'h0000_6081, 1'b1};
      cvec[10] = '{16'h9005, 32'h0000_9005, 1'b1};
      cvec[11] = '{16'h852e, 32'h00b0_0533, 1'b0};
      cvec[12] = '{16'h952e, 32'h00b5_0533, 1'b0};
      cvec[13] = '{16'h4002, 32'h0000_4002, 1'b1};
      cvec[14] = '{16'ha001, 32'h0000_006f, 1'b0};
      cvec[15] = '{16'hc101, 32'h0005_0063, 1'b0};
      cvec[16] = '{16'h0506, 32'h0015_1513, 1'b0};
      cvec[17] = '{16'h0048, 32'h0041_0513, 1'b0};
      cvec[18] = '{16'h2009, 32'h0020_00ef, 1'b0};
      cvec[19] = '{16'hfd7d, 32'hfe05_1fe3, 1'b0};

      // Reset with a fetch presented: nothing may be accepted.
      reset = 1'b1; flush = 1'b0; flush_pc = '0; inst_ready = 1'b0;
      fetch_valid = 1'b1; fetch_data = 32'h0000_0013; fetch_pc = '0;
      repeat (3) step();
      #1;
      chk("reset_fready", fetch_ready, 1'b0);
      chk("reset_outputs", {inst_valid, inst_data, inst_pc, inst_is_compressed, inst_illegal}, '0);
      reset = 1'b0; fetch_valid = 1'b0;
      #1;
      chk("post_reset", {fetch_ready, inst_valid}, 2'b10);

      do_fetch(32'h0000_0013, 32'h0);
      expect_inst("single32", 32'h0000_0013, 32'h0, 1'b0, 1'b0);

      do_flush(32'h100);
      do_fetch(32'h4501_4501, 32'h100);
      chk("nc_illegal", {fetch_ready0, inst_valid0, inst_ill0, inst_c0, inst_data0, inst_pc0},
          {4'b1111, 32'h0000_4501, 32'h100});
      expect_inst("pair_lo", 32'h0000_0513, 32'h100, 1'b1, 1'b0);
      expect_inst("pair_hi", 32'h0000_0513, 32'h102, 1'b1, 1'b0);

      do_flush(32'h200);
      do_fetch(32'h0513_4501, 32'h200);
      do_fetch(32'h4501_0000, 32'h204);
      expect_inst("strad_c0", 32'h0000_0513, 32'h200, 1'b1, 1'b0);
      expect_inst("strad_32", 32'h0000_0513, 32'h202, 1'b0, 1'b0);
      expect_inst("strad_c1", 32'h0000_0513, 32'h206, 1'b1, 1'b0);

      // Consumer stalled while fetch keeps pushing.
      do_flush(32'h500);
      fpc = 32'h500; accepted = 0;
      for (int i = 0; i < 6; i++) begin
         fetch_valid = 1'b1; fetch_data = 32'h4501_4501; fetch_pc = fpc;
         #1;
         chk("stall_fready", fetch_ready, (i < 2));
         if (i >= 1) chk("stall_hold", {inst_valid, inst_pc, inst_data}, {1'b1, 32'h500, 32'h513});
         if (fetch_ready) begin
            accepted++;
            fpc += 4;
         end
         step();
      end
      fetch_valid = 1'b0;
      chk("stall_accepted", accepted, 2);
      for (int i = 0; i < 4; i++) begin
         expect_inst("stall_drain", 32'h0000_0513, 32'h500 + 2 * i, 1'b1, 1'b0);
      end
      #1;
      chk("stall_empty", inst_valid, 1'b0);

      // Flush with three stale halfwords and a fetch offered in the flush cycle.
      do_flush(32'h300);
      do_fetch(32'h0001_0001, 32'h300);
      do_fetch(32'h0001_ffff, 32'h302);
      fetch_valid = 1'b1; fetch_data = 32'h0001_0001; fetch_pc = 32'h304;
      do_flush(32'h302);
      fetch_valid = 1'b0;
      #1;
      chk("flush_empty", inst_valid, 1'b0);
      do_fetch(32'h4501_abcd, 32'h302);
      expect_inst("after_flush", 32'h0000_0513, 32'h302, 1'b1, 1'b0);
      #1;
      chk("after_flush_empty", inst_valid, 1'b0);

      do_flush(32'h400);
      do_fetch(32'h0000_0000, 32'h400);
      expect_inst("zero_lo", 32'h0, 32'h400, 1'b1, 1'b1);
      expect_inst("zero_hi", 32'h0, 32'h402, 1'b1, 1'b1);

      // Reset mid-stream beats a simultaneous flush.
      do_flush(32'h600);
      do_fetch(32'h0001_0001, 32'h600);
      reset = 1'b1; flush = 1'b1; flush_pc = 32'h40;
      #1;
      chk("midreset", {fetch_ready, inst_valid}, 2'b00);
      step();
      reset = 1'b0; flush = 1'b0;
      do_fetch(32'h00a0_0093, 32'h0);
      expect_inst("midreset_inst", 32'h00a0_0093, 32'h0, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         do_flush(32'h1002 + 8 * i);
         do_fetch({cvec[i].hw, 16'hffff}, 32'h1002 + 8 * i);
         expect_inst($sformatf("cvec%0d", i), cvec[i].data, 32'h1002 + 8 * i, 1'b1, cvec[i].ill);
      end

      // Random streams; model tracks halfwords held and the in-order instruction list.
      for (int r = 0; r < 3; r++) begin
         logic [31:0] p, ipc, w;
         logic [15:0] prog [$];
         int          cnt, fi, cyc, j, n;
         logic        push, pop;
         p = (r == 2) ? 32'hffff_ffc2 : ($urandom & 32'h0000_fffe);
         prog.delete();
         exp_q.delete();
         ipc = p;
         for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0) begin
               w = $urandom | 32'h3;
               prog.push_back(w[15:0]);
               prog.push_back(w[31:16]);
               exp_q.push_back('{w, ipc, 1'b0, 1'b0, 2});
               ipc += 4;
            end else begin
               j = $urandom_range(0, 19);
               prog.push_back(cvec[j].hw);
               exp_q.push_back('{cvec[j].data, ipc, 1'b1, cvec[j].ill, 1});
               ipc += 2;
            end
         end
         if (((prog.size() + int'(p[1])) % 2) != 0) begin
            prog.push_back(16'h0001);
            exp_q.push_back('{32'h0000_0013, ipc, 1'b1, 1'b0, 1});
         end
         do_flush(p);
         fpc = p; fi = 0; cnt = 0; cyc = 0;
         while (exp_q.size() > 0 && cyc < 3000) begin
            if (fi < prog.size() && $urandom_range(0, 3) != 0) begin
               fetch_valid = 1'b1;
               fetch_pc    = fpc;
               fetch_data  = fpc[1] ? {prog[fi], 16'hbeef} : {prog[fi+1], prog[fi]};
            end else begin
               fetch_valid = 1'b0;
            end
            inst_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rand_fready", fetch_ready, (BUF_HW - cnt) >= 2);
            chk("rand_ivalid", inst_valid, cnt >= exp_q[0].size);
            if (inst_valid) begin
               chk("rand_inst", {inst_data, inst_pc, inst_is_compressed, inst_illegal},
                   {exp_q[0].data, exp_q[0].pc, exp_q[0].c, exp_q[0].ill});
            end
            push = fetch_valid && ((BUF_HW - cnt) >= 2);
            pop  = inst_ready && (cnt >= exp_q[0].size);
            if (pop) begin
               $display("inst rand pc=%h data=%h c=%0d ill=%0d", exp_q[0].pc, exp_q[0].data,
                        exp_q[0].c, exp_q[0].ill);
               cnt -= exp_q[0].size;
               void'(exp_q.pop_front());
            end
            if (push) begin
               n    = fpc[1] ? 1 : 2;
               cnt += n;
               fi  += n;
               fpc += 32'(2 * n);
            end
            step();
            cyc++;
         end
         fetch_valid = 1'b0;
         inst_ready  = 1'b0;
         chk("rand_drain", exp_q.size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
